// File: rtl/joy_dir_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
// Direction nibble layout: bit3=up, bit2=down, bit1=left, bit0=right.
package joy_dir_pkg;

  typedef enum logic [1:0] {
    MODE_PASS       = 2'd0,
    MODE_FOUR_LAST  = 2'd1,
    MODE_FOUR_FIRST = 2'd2,
    MODE_EIGHT_SOCD = 2'd3
  } mode_e;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Winner memory for one opposing pair (up/down or left/right).
  // FIRST is the higher-priority member of the pair (up or left).
  typedef enum logic [1:0] {
    PAIR_NONE   = 2'd0,
    PAIR_FIRST  = 2'd1,
    PAIR_SECOND = 2'd2
  } pair_e;

  typedef struct packed {
    pair_e trk;
    logic  first;
    logic  second;
  } pair_res_t;

  // One-hot of the highest-priority pressed bit: up > down > left > right.
  function automatic logic [3:0] prio_pick(input logic [3:0] v);
    logic [3:0] res;
    res = '0;
    if (v[DIR_UP])         res[DIR_UP]    = 1'b1;
    else if (v[DIR_DOWN])  res[DIR_DOWN]  = 1'b1;
    else if (v[DIR_LEFT])  res[DIR_LEFT]  = 1'b1;
    else if (v[DIR_RIGHT]) res[DIR_RIGHT] = 1'b1;
    return res;
  endfunction

  // Resolve one opposing pair: a lone press passes, when both are held the
  // later riser wins, and a simultaneous rise cancels both.
  function automatic pair_res_t socd_resolve(input logic  held_first,
                                             input logic  held_second,
                                             input logic  rise_first,
                                             input logic  rise_second,
                                             input pair_e trk);
    pair_res_t res;
    res.trk    = PAIR_NONE;
    res.first  = held_first & ~held_second;
    res.second = held_second & ~held_first;
    if (held_first && held_second) begin
      if (rise_first && rise_second) res.trk = PAIR_NONE;
      else if (rise_first)           res.trk = PAIR_FIRST;
      else if (rise_second)          res.trk = PAIR_SECOND;
      else                           res.trk = trk;
      res.first  = (res.trk == PAIR_FIRST);
      res.second = (res.trk == PAIR_SECOND);
    end
    return res;
  endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// One joystick direction channel: input sync (or debounce when
// JOY_DEBOUNCE_EN is defined), 4-way mask FSM, 8-way SOCD pair trackers,
// registered output and a one-cycle change strobe.
module joy_dir_chan
  import joy_dir_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  mode_e      i_mode,
  input  logic [3:0] i_dir,
  output logic [3:0] o_dir,
  output logic       o_changed
);

  logic [3:0] w_s1;
  logic [3:0] r_s2;
  logic [3:0] w_rise;
  mode_e      r_mode_prev;
  logic       w_mode_chg;
  logic [3:0] r_mask;
  logic [3:0] w_mask_cur;
  logic [3:0] w_mask_next;
  pair_e      r_vt;
  pair_e      r_hz;
  pair_e      w_vt_cur;
  pair_e      w_hz_cur;
  pair_e      w_vt_next;
  pair_e      w_hz_next;
  pair_res_t  w_vt_res;
  pair_res_t  w_hz_res;
  logic [3:0] w_out_next;
  logic [3:0] r_out;
  logic       r_changed;

  genvar gi;

`ifdef JOY_DEBOUNCE_EN
  localparam int             CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_CYCLES);

  for (gi = 0; gi < 4; gi++) begin : g_deb
    logic          r_lvl;
    logic [CW-1:0] r_cnt;

    // Accept a new level only once it has persisted past DEB_CYCLES samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_lvl <= 1'b0;
        r_cnt <= '0;
      end else if (i_dir[gi] != r_lvl) begin
        if (r_cnt == DEB_MAX) begin
          r_lvl <= i_dir[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_s1[gi] = r_lvl;
  end
`else
  logic [3:0] r_s1;

  // First input stage: plain register of the raw directions.
  always_ff @(posedge clk) begin
    if (reset) r_s1 <= '0;
    else       r_s1 <= i_dir;
  end

  assign w_s1 = r_s1;

  // DEB_CYCLES has no effect without debouncing; referenced here so both
  // builds share one parameter list.
  if (DEB_CYCLES < 1) begin : g_deb_unused
  end
`endif

  // Second input stage (for rise detection) and last-seen mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2        <= '0;
      r_mode_prev <= MODE_PASS;
    end else begin
      r_s2        <= w_s1;
      r_mode_prev <= i_mode;
    end
  end

  assign w_rise     = w_s1 & ~r_s2;
  assign w_mode_chg = (i_mode != r_mode_prev);

  // A mode switch discards history: the next state is computed as if idle,
  // so the output re-derives from the held inputs under the new mode.
  assign w_mask_cur = w_mode_chg ? 4'b0000 : r_mask;
  assign w_vt_cur   = w_mode_chg ? PAIR_NONE : r_vt;
  assign w_hz_cur   = w_mode_chg ? PAIR_NONE : r_hz;

  assign w_vt_res = socd_resolve(w_s1[DIR_UP], w_s1[DIR_DOWN],
                                 w_rise[DIR_UP], w_rise[DIR_DOWN], w_vt_cur);
  assign w_hz_res = socd_resolve(w_s1[DIR_LEFT], w_s1[DIR_RIGHT],
                                 w_rise[DIR_LEFT], w_rise[DIR_RIGHT], w_hz_cur);

  // Next-state and next-output selection for the active mode.
  always_comb begin
    w_mask_next = 4'b0000;
    w_vt_next   = PAIR_NONE;
    w_hz_next   = PAIR_NONE;
    w_out_next  = w_s1;
    case (i_mode)
      MODE_PASS: begin
        w_out_next = w_s1;
      end
      MODE_FOUR_LAST: begin
        if (w_rise != 4'b0000)                   w_mask_next = prio_pick(w_rise);
        else if ((w_s1 & w_mask_cur) == 4'b0000) w_mask_next = prio_pick(w_s1);
        else                                     w_mask_next = w_mask_cur;
        w_out_next = w_s1 & w_mask_next;
      end
      MODE_FOUR_FIRST: begin
        // Idle and released-held both fall back to the best still-held bit.
        if ((w_s1 & w_mask_cur) == 4'b0000) w_mask_next = prio_pick(w_s1);
        else                                w_mask_next = w_mask_cur;
        w_out_next = w_s1 & w_mask_next;
      end
      MODE_EIGHT_SOCD: begin
        w_vt_next  = w_vt_res.trk;
        w_hz_next  = w_hz_res.trk;
        w_out_next = {w_vt_res.first, w_vt_res.second,
                      w_hz_res.first, w_hz_res.second};
      end
      default: begin
        w_out_next = w_s1;
      end
    endcase
  end

  // Filter state, registered output and change strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= 4'b0000;
      r_vt      <= PAIR_NONE;
      r_hz      <= PAIR_NONE;
      r_out     <= 4'b0000;
      r_changed <= 1'b0;
    end else begin
      r_mask    <= w_mask_next;
      r_vt      <= w_vt_next;
      r_hz      <= w_hz_next;
      r_out     <= w_out_next;
      r_changed <= (w_out_next != r_out);
    end
  end

  assign o_dir     = r_out;
  assign o_changed = r_changed;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: NUM_PLAYERS independent
// channels, each with a runtime mode (pass / 4-way last / 4-way first /
// 8-way SOCD). Optional input debouncing is enabled by JOY_DEBOUNCE_EN.
module joy_dir_filter
  import joy_dir_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*NUM_PLAYERS-1:0] mode,
  input  logic [4*NUM_PLAYERS-1:0] dir_in,
  output logic [4*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   changed
);

  genvar gi;

  for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_chan
    mode_e w_mode;

    assign w_mode = mode_e'(mode[2*gi +: 2]);

    joy_dir_chan #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_mode    (w_mode),
      .i_dir     (dir_in[4*gi +: 4]),
      .o_dir     (dir_out[4*gi +: 4]),
      .o_changed (changed[gi])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench for joy_dir_filter. Default build: directed scenarios
// plus randomized stimulus against a timestamp/selection-based reference
// model. With JOY_DEBOUNCE_EN: debounce pulse-rejection and latency checks.
module tb_joy_dir_filter;

  localparam int NP  = 2;
  localparam int DEB = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*NP-1:0] mode;
  logic [4*NP-1:0] dir_in;
  logic [4*NP-1:0] dir_out;
  logic [NP-1:0]   changed;

  int n_checks = 0;
  int n_errors = 0;

  joy_dir_filter #(
    .NUM_PLAYERS (NP),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .dir_in  (dir_in),
    .dir_out (dir_out),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_dir(input int ch, input logic [3:0] v);
    dir_in[ch*4 +: 4] = v;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[ch*2 +: 2] = m;
  endtask

`ifndef JOY_DEBOUNCE_EN
  // Reference model: sampled inputs, a selected direction index for the
  // 4-way modes, and per-direction press timestamps for SOCD.
  logic [3:0] m_s1 [NP];
  logic [3:0] m_s2 [NP];
  logic [1:0] m_mode_prev [NP];
  int         m_sel [NP];
  int         m_pt [NP][4];
  logic [3:0] m_out [NP];
  logic       m_chg [NP];
  int         cyc = 0;

  function automatic int pick(input logic [3:0] v);
    for (int d = 3; d >= 0; d--) if (v[d]) return d;
    return -1;
  endfunction

  function automatic logic [1:0] pair_out(input logic ha, input logic hb, input int ta, input int tb);
    if (ha && hb) return (ta > tb) ? 2'b10 : ((tb > ta) ? 2'b01 : 2'b00);
    return {ha, hb};
  endfunction

  task automatic model_step();
    logic [3:0] s1, rise, out;
    logic [1:0] md;
    logic       mchg;
    int         sel;
    cyc++;
    for (int ch = 0; ch < NP; ch++) begin
      if (reset) begin
        m_s1[ch] = '0; m_s2[ch] = '0; m_mode_prev[ch] = '0;
        m_sel[ch] = -1; m_out[ch] = '0; m_chg[ch] = 1'b0;
        for (int d = 0; d < 4; d++) m_pt[ch][d] = 0;
      end else begin
        s1   = m_s1[ch];
        rise = s1 & ~m_s2[ch];
        md   = mode[ch*2 +: 2];
        mchg = (md != m_mode_prev[ch]);
        sel  = mchg ? -1 : m_sel[ch];
        out  = s1;
        case (md)
          2'd1: begin
            if (rise != 4'b0) sel = pick(rise);
            else if (sel < 0 || !s1[sel]) sel = pick(s1);
          end
          2'd2: if (sel < 0 || !s1[sel]) sel = pick(s1);
          default: sel = -1;
        endcase
        if (md == 2'd1 || md == 2'd2) out = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
        if (md == 2'd3) begin
          for (int d = 0; d < 4; d++) if (mchg && s1[d]) m_pt[ch][d] = 2*cyc - 1;
          for (int d = 0; d < 4; d++) if (rise[d]) m_pt[ch][d] = 2*cyc;
          out[3:2] = pair_out(s1[3], s1[2], m_pt[ch][3], m_pt[ch][2]);
          out[1:0] = pair_out(s1[1], s1[0], m_pt[ch][1], m_pt[ch][0]);
        end
        m_chg[ch]       = (out != m_out[ch]);
        m_out[ch]       = out;
        m_sel[ch]       = sel;
        m_mode_prev[ch] = md;
        m_s2[ch]        = m_s1[ch];
        m_s1[ch]        = dir_in[ch*4 +: 4];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < NP; ch++) begin
      check($sformatf("mdl_out%0d", ch), 32'(dir_out[ch*4 +: 4]), 32'(m_out[ch]));
      check($sformatf("mdl_chg%0d", ch), 32'(changed[ch]), 32'(m_chg[ch]));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
`else
  task automatic tick_raw();
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    reset  = 1'b1;
    mode   = '0;
    dir_in = '0;
`ifdef JOY_DEBOUNCE_EN
    begin
      int n;
      repeat (3) tick_raw();
      reset = 1'b0;
      repeat (5) tick_raw();
      check("deb_idle", 32'(dir_out[3:0]), 32'h0);
      dir_in[0] = 1'b1;
      repeat (10) tick_raw();
      dir_in[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick_raw();
        check("deb_short", 32'(dir_out[0]), 32'h0);
      end
      $display("[%0t] debounce: 10-cycle pulse out=%b", $time, dir_out[3:0]);
      dir_in[0] = 1'b1;
      n = 0;
      while (dir_out[0] !== 1'b1 && n < 60) begin
        tick_raw();
        n++;
      end
      check("deb_latency", 32'(n), 32'd18);
      $display("[%0t] debounce: 20-cycle pulse latency=%0d", $time, n);
      repeat (2) tick_raw();
      dir_in[0] = 1'b0;
      repeat (25) tick_raw();
      check("deb_release", 32'(dir_out[0]), 32'h0);
    end
`else
    // Reset with all directions held, FOUR_LAST on ch0.
    set_mode(0, 2'd1);
    set_dir(0, 4'hF);
    ticks(3);
    check("rst_out0", 32'(dir_out[3:0]), 32'h0);
    check("rst_chg", 32'(changed), 32'h0);
    reset = 1'b0;
    ticks(2);
    check("rst_up", 32'(dir_out[3:0]), 32'h8);
    check("rst_up_chg", 32'(changed[0]), 32'h1);
    $display("[%0t] reset release ch0 out=%b", $time, dir_out[3:0]);

    // FOUR_LAST: right, add up, release up.
    set_dir(0, 4'b0001); ticks(2);
    check("fl_right", 32'(dir_out[3:0]), 32'h1);
    check("fl_right_chg", 32'(changed[0]), 32'h1);
    set_dir(0, 4'b1001); ticks(2);
    check("fl_up", 32'(dir_out[3:0]), 32'h8);
    check("fl_up_chg", 32'(changed[0]), 32'h1);
    set_dir(0, 4'b0001); ticks(2);
    check("fl_fallback", 32'(dir_out[3:0]), 32'h1);
    check("fl_fallback_chg", 32'(changed[0]), 32'h1);
    $display("[%0t] four_last ch0 out=%b", $time, dir_out[3:0]);

    // FOUR_FIRST on ch1: left held, down ignored, release left.
    set_mode(1, 2'd2); set_dir(1, 4'b0000); ticks(3);
    set_dir(1, 4'b0010); ticks(2);
    check("ff_left", 32'(dir_out[7:4]), 32'h2);
    set_dir(1, 4'b0110); ticks(2);
    check("ff_hold", 32'(dir_out[7:4]), 32'h2);
    check("ff_hold_chg", 32'(changed[1]), 32'h0);
    set_dir(1, 4'b0100); ticks(2);
    check("ff_down", 32'(dir_out[7:4]), 32'h4);
    $display("[%0t] four_first ch1 out=%b", $time, dir_out[7:4]);

    // EIGHT_SOCD on ch0.
    set_mode(0, 2'd3); set_dir(0, 4'b0000); ticks(3);
    set_dir(0, 4'b0010); ticks(2);
    set_dir(0, 4'b0011); ticks(2);
    check("socd_lr", 32'(dir_out[3:0]), 32'h1);
    set_dir(0, 4'b0000); ticks(2);
    set_dir(0, 4'b1100); ticks(2);
    check("socd_ud_same", 32'(dir_out[3:0]), 32'h0);
    set_dir(0, 4'b0000); ticks(2);
    set_dir(0, 4'b1001); ticks(2);
    check("socd_diag", 32'(dir_out[3:0]), 32'h9);
    $display("[%0t] socd ch0 out=%b", $time, dir_out[3:0]);

    // Mode switch on ch0 while ch1 toggles in PASS.
    set_mode(0, 2'd0); set_mode(1, 2'd0);
    set_dir(0, 4'b1010); set_dir(1, 4'b0000); ticks(3);
    check("ms_pass", 32'(dir_out[3:0]), 32'hA);
    set_mode(0, 2'd1); set_dir(1, 4'b0001); ticks(2);
    check("ms_ch0", 32'(dir_out[3:0]), 32'h8);
    check("ms_ch1", 32'(dir_out[7:4]), 32'h1);
    $display("[%0t] mode switch ch0 out=%b ch1 out=%b", $time, dir_out[3:0], dir_out[7:4]);

    // Randomized traffic against the model.
    for (int burst = 0; burst < 6; burst++) begin
      for (int i = 0; i < 500; i++) begin
        for (int ch = 0; ch < NP; ch++) begin
          if ($urandom_range(0, 3) == 0) set_dir(ch, 4'($urandom));
          if ($urandom_range(0, 99) == 0) set_mode(ch, 2'($urandom_range(0, 3)));
        end
        reset = ($urandom_range(0, 499) == 0);
        tick();
      end
      $display("[%0t] random burst %0d done, errors so far %0d", $time, burst, n_errors);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
